// File: rtl/writeback_stage_pkg.sv
// ---------------------------------------------------------------------------
// writeback_stage_pkg : constants and types shared by W, Decode and the hazard unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package writeback_stage_pkg;

  localparam logic [3:0] PC_REG = 4'd15;
  localparam int         WORD_W = 32;

  typedef enum logic {
    RESULT_ALU = 1'b0,
    RESULT_MEM = 1'b1
  } result_sel_e;

endpackage

`default_nettype wire

// File: rtl/wb_flush_timer.sv
// ---------------------------------------------------------------------------
// wb_flush_timer : holds the front-end flush request for FLUSH_CYCLES per redirect
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_flush_timer #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam logic [2:0] C_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // A redirect inside an open window reloads the count rather than adding to it.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = C_RELOAD;
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = start | (cnt_q != 3'd0);

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage : W pipeline register, result select, register-file write port,
//                   PC redirect on R15 writes and same-cycle bypass flags for Decode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int WIDTH        = WORD_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Flush,
  input  logic             M_Valid,
  input  logic             M_RegWrite,
  input  logic             M_MemtoReg,
  input  logic [3:0]       M_Rd,
  input  logic [WIDTH-1:0] M_ALUResult,
  input  logic [WIDTH-1:0] M_ReadData,
  input  logic [3:0]       RA1,
  input  logic [3:0]       RA2,
  output logic             WE3,
  output logic [3:0]       A3,
  output logic [WIDTH-1:0] WD3,
  output logic             PCWrite,
  output logic [WIDTH-1:0] PCTarget,
  output logic             FlushReq,
  output logic             FwdA,
  output logic             FwdB
);

  logic             valid_q;
  logic             regwrite_q;
  result_sel_e      memtoreg_q;
  logic [3:0]       rd_q;
  logic [WIDTH-1:0] alu_q;
  logic [WIDTH-1:0] rdata_q;

  // A killed slot only needs its valid bit cleared; the payload is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= RESULT_ALU;
      rd_q       <= 4'd0;
      alu_q      <= '0;
      rdata_q    <= '0;
    end else begin
      valid_q    <= M_Valid & ~Flush;
      regwrite_q <= M_RegWrite;
      memtoreg_q <= result_sel_e'(M_MemtoReg);
      rd_q       <= M_Rd;
      alu_q      <= M_ALUResult;
      rdata_q    <= M_ReadData;
    end
  end

  logic w_write;
  logic w_rd_is_pc;

  assign w_write    = valid_q & regwrite_q;
  assign w_rd_is_pc = (rd_q == PC_REG);

  assign WD3      = (memtoreg_q == RESULT_MEM) ? rdata_q : alu_q;
  assign A3       = rd_q;
  assign WE3      = w_write & ~w_rd_is_pc;
  assign PCWrite  = w_write & w_rd_is_pc;
  assign PCTarget = WD3;

  // WE3 already excludes R15, so PC reads in Decode are never bypassed.
  assign FwdA = WE3 & (A3 == RA1);
  assign FwdB = WE3 & (A3 == RA2);

  wb_flush_timer #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_timer (
    .clk   (clk),
    .rst   (rst),
    .start (PCWrite),
    .busy  (FlushReq)
  );

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage : directed vectors, queued expectations, negedge monitor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, Flush, M_Valid, M_RegWrite, M_MemtoReg;
  logic [3:0]  M_Rd, RA1, RA2;
  logic [31:0] M_ALUResult, M_ReadData;
  logic        WE3, PCWrite, FlushReq, FwdA, FwdB;
  logic [3:0]  A3;
  logic [31:0] WD3, PCTarget;

  writeback_stage #(
    .WIDTH        (32),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Flush       (Flush),
    .M_Valid     (M_Valid),
    .M_RegWrite  (M_RegWrite),
    .M_MemtoReg  (M_MemtoReg),
    .M_Rd        (M_Rd),
    .M_ALUResult (M_ALUResult),
    .M_ReadData  (M_ReadData),
    .RA1         (RA1),
    .RA2         (RA2),
    .WE3         (WE3),
    .A3          (A3),
    .WD3         (WD3),
    .PCWrite     (PCWrite),
    .PCTarget    (PCTarget),
    .FlushReq    (FlushReq),
    .FwdA        (FwdA),
    .FwdB        (FwdB)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        we3;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic        pcw;
    logic        fr;
    logic        fa;
    logic        fb;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   step_id = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL step %0d %s: got 0x%0h, expected 0x%0h", id, name, act, exp);
    end
  endtask

  // Outputs are stable mid-cycle; each negedge retires one expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("WE3",      e.id, {31'd0, WE3},      {31'd0, e.we3});
      chk("PCWrite",  e.id, {31'd0, PCWrite},  {31'd0, e.pcw});
      chk("FlushReq", e.id, {31'd0, FlushReq}, {31'd0, e.fr});
      chk("FwdA",     e.id, {31'd0, FwdA},     {31'd0, e.fa});
      chk("FwdB",     e.id, {31'd0, FwdB},     {31'd0, e.fb});
      if (e.chk_data) begin
        chk("A3",       e.id, {28'd0, A3}, {28'd0, e.a3});
        chk("WD3",      e.id, WD3,         e.wd3);
        chk("PCTarget", e.id, PCTarget,    e.wd3);
      end
    end
  end

  // Drive M-stage inputs for the coming edge; RA1/RA2 and the expectation
  // describe the W state that edge produces.
  task automatic step(
    input logic r, input logic f, input logic v, input logic rw, input logic m2r,
    input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] rdat,
    input logic [3:0] ra1, input logic [3:0] ra2,
    input logic e_we, input logic [3:0] e_a3, input logic [31:0] e_wd,
    input logic e_pcw, input logic e_fr, input logic e_fa, input logic e_fb,
    input logic e_chk);
    exp_t e;
    rst = r; Flush = f; M_Valid = v; M_RegWrite = rw; M_MemtoReg = m2r;
    M_Rd = rd; M_ALUResult = alu; M_ReadData = rdat;
    @(posedge clk);
    #1;
    RA1 = ra1; RA2 = ra2;
    step_id++;
    e.id = step_id; e.we3 = e_we; e.a3 = e_a3; e.wd3 = e_wd; e.pcw = e_pcw;
    e.fr = e_fr; e.fa = e_fa; e.fb = e_fb; e.chk_data = e_chk;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(0,0,0,0,0, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0,  0, 4'd0, 32'h0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; Flush = 1'b0; M_Valid = 1'b0; M_RegWrite = 1'b0; M_MemtoReg = 1'b0;
    M_Rd = 4'd0; M_ALUResult = '0; M_ReadData = '0; RA1 = 4'd0; RA2 = 4'd0;

    // reset held two cycles with a live write on the M inputs
    step(1,0,1,1,0, 4'd3, 32'hAA, 32'hBB, 4'd3, 4'd3,  0, 4'd0, 32'h0, 0, 0, 0, 0, 1);
    step(1,0,1,1,0, 4'd3, 32'hAA, 32'hBB, 4'd3, 4'd3,  0, 4'd0, 32'h0, 0, 0, 0, 0, 1);
    idle();

    // ALU result write, then load write
    step(0,0,1,1,0, 4'd3, 32'h12345678, 32'h55, 4'd3, 4'd4,  1, 4'd3, 32'h12345678, 0, 0, 1, 0, 1);
    step(0,0,1,1,1, 4'd7, 32'h100, 32'hDEADBEEF, 4'd1, 4'd7,  1, 4'd7, 32'hDEADBEEF, 0, 0, 0, 1, 1);

    // single redirect: FlushReq for exactly two cycles
    step(0,0,1,1,0, 4'd15, 32'h40, 32'h0, 4'd15, 4'd15,  0, 4'd15, 32'h40, 1, 1, 0, 0, 1);
    step(0,0,0,1,0, 4'd15, 32'h40, 32'h0, 4'd15, 4'd15,  0, 4'd15, 32'h40, 0, 1, 0, 0, 1);
    idle();

    // back-to-back redirects restart the window
    step(0,0,1,1,0, 4'd15, 32'h80, 32'h0, 4'd0, 4'd0,  0, 4'd15, 32'h80, 1, 1, 0, 0, 1);
    step(0,0,1,1,0, 4'd15, 32'h84, 32'h0, 4'd0, 4'd0,  0, 4'd15, 32'h84, 1, 1, 0, 0, 1);
    step(0,0,0,0,0, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0,     0, 4'd0, 32'h0, 0, 1, 0, 0, 1);
    idle();

    // Flush input does not cut an open window short
    step(0,0,1,1,0, 4'd15, 32'hC0, 32'h0, 4'd0, 4'd0,  0, 4'd15, 32'hC0, 1, 1, 0, 0, 1);
    step(0,1,1,1,0, 4'd2, 32'h11, 32'h0, 4'd2, 4'd2,   0, 4'd0, 32'h0, 0, 1, 0, 0, 0);
    idle();

    // bypass flags
    step(0,0,1,1,0, 4'd5, 32'h55, 32'h0, 4'd5, 4'd6,   1, 4'd5, 32'h55, 0, 0, 1, 0, 1);
    step(0,0,1,1,0, 4'd5, 32'h66, 32'h0, 4'd6, 4'd5,   1, 4'd5, 32'h66, 0, 0, 0, 1, 1);
    step(0,0,1,1,0, 4'd15, 32'h100, 32'h0, 4'd15, 4'd15, 0, 4'd15, 32'h100, 1, 1, 0, 0, 1);
    step(0,0,1,0,0, 4'd5, 32'h77, 32'h0, 4'd5, 4'd5,   0, 4'd5, 32'h77, 0, 1, 0, 0, 1);
    idle();

    // kill: Flush beats a valid write and a valid redirect
    step(0,1,1,1,0, 4'd2, 32'h22, 32'h0, 4'd2, 4'd2,   0, 4'd0, 32'h0, 0, 0, 0, 0, 0);
    step(0,1,1,1,0, 4'd15, 32'h200, 32'h0, 4'd15, 4'd15, 0, 4'd0, 32'h0, 0, 0, 0, 0, 0);

    // reset inside a FlushReq window
    step(0,0,1,1,0, 4'd15, 32'h300, 32'h0, 4'd0, 4'd0, 0, 4'd15, 32'h300, 1, 1, 0, 0, 1);
    step(1,0,1,1,0, 4'd15, 32'h300, 32'h0, 4'd15, 4'd15, 0, 4'd0, 32'h0, 0, 0, 0, 0, 1);
    idle();

    repeat (2) @(posedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
